linear_network_dispatcher: RTL and testbench
============================================

# linear_network_dispatcher

Upstream feeder for the sequential unicast linear network.
- Accepts a valid/ready stream of data words, each with an optional destination tag, and buffers them in a small FIFO.
- Issues at most one word per cycle as the network's `valid` / `data` / `cmd` triple, using either the explicit tag or a round-robin node pointer.
- Drives the network enable and holds it high until every issued word has propagated to the last node, so no in-flight data is flushed.

## Interface
Parameters:
- `DATA_WIDTH`, 32, payload width.
- `NUM_NODE`, 4, number of network nodes, ≥2. `CMD_W = $clog2(NUM_NODE)`.
- `FIFO_DEPTH`, 4, entries; must be a power of 2, ≥2.

Ports (clock and reset first):
- `clk` input 1 — single clock; all logic is on its rising edge.
- `rst` input 1 — reset, synchronous and active-high.
- `i_valid` input 1 — upstream word valid.
- `i_data` input DATA_WIDTH — upstream payload.
- `i_dest` input CMD_W — explicit destination node id.
- `o_ready` output 1 — dispatcher can accept a word this cycle.
- `i_mode` input 1 — 0 = explicit destination (`i_dest`), 1 = round-robin.
- `i_issue_en` input 1 — issue permission; 0 stalls issue only.
- `o_valid` output 1 — to network `i_valid`.
- `o_data_bus` output DATA_WIDTH — to network `i_data_bus`.
- `o_cmd` output CMD_W — to network `i_cmd`.
- `o_en` output 1 — to network `i_en`.
- `o_busy` output 1 — FIFO non-empty or words still in flight.
- `o_issue_cnt` output 16 — count of words issued with `o_valid`=1; wraps.
- `o_drop_cnt` output 16 — count of words dropped for an illegal destination; wraps.

## Operation
FIFO:
- Each entry stores `{dest, data}`.
- `o_ready = ~full`, combinational from FIFO state.
- Push occurs when `i_valid && o_ready`. `dest` is captured as `i_dest` when `i_mode`=0, or as the current `rr_ptr` when `i_mode`=1.
- `rr_ptr` advances by 1 per push in mode 1 and wraps from NUM_NODE-1 to 0. It is unchanged by pushes in mode 0.
- No push is accepted when full, even if a pop happens in the same cycle.
- Push into an empty FIFO does not bypass it. The entry becomes visible on the following cycle.
- Read and write pointers are `$clog2(FIFO_DEPTH)+1` bits; the extra bit distinguishes full from empty across wrap-around.

Issue:
- A pop happens in a cycle when `i_issue_en && !empty`. It registers one output word.
- If the entry's dest < NUM_NODE: next cycle `o_valid`=1, `o_data_bus`=data, `o_cmd`=dest, and `o_issue_cnt` increments.
- If the entry's dest ≥ NUM_NODE (possible only when NUM_NODE is not a power of 2): next cycle `o_valid`=0, `o_data_bus`=0, `o_cmd`=0, and `o_drop_cnt` increments.
- With no pop: next cycle `o_valid`=0, `o_data_bus`=0, `o_cmd`=0. Idle outputs are always all-zero.

Drain / enable:
- `drain_cnt` is CMD_W+1 bits wide.
- It loads NUM_NODE-1 when a valid word is issued. Otherwise it decrements toward 0 and saturates at 0.
- `o_en` is registered: 1 in the cycle a valid word is presented on `o_valid`, and in every cycle while `drain_cnt` ≠ 0.
- The net effect is that `o_en` stays high for NUM_NODE consecutive cycles starting at the word's `o_valid` cycle, and is extended by later issues.
- `o_busy = !empty || o_en`.
- `i_issue_en`=0 never drops `o_en` while words are in flight.

## Timing
- Reset: with `rst`=1 at a rising edge, the following clear on that edge:
  - FIFO pointers (FIFO becomes empty) and `rr_ptr`=0.
  - `drain_cnt`=0.
  - `o_valid`=0, `o_data_bus`=0, `o_cmd`=0, `o_en`=0.
  - `o_issue_cnt`=0, `o_drop_cnt`=0.
- After reset, `o_ready`=1 and `o_busy`=0.
- A reset mid-operation discards buffered and in-flight words; the network is reset in the same cycle.
- Minimum latency: a word accepted at edge E0 appears on `o_valid` after edge E1 (2 cycles).
- Throughput: 1 word per cycle while `i_issue_en`=1 and the FIFO is non-empty.
- Simultaneous push and pop with a non-full FIFO: both occur and occupancy is unchanged.
- An `i_mode` change affects only words pushed after the change; buffered entries keep their stored dest.

## Test plan
- Reset, then push data 0xA1, 0xB2, 0xC3 with `i_mode`=0 and `i_dest`=3, 0, 2, `i_issue_en`=1 → `o_valid` high on 3 consecutive cycles starting 2 cycles after the first accept, with `o_cmd` 3, 0, 2 and matching data. `o_en` stays high until 3 cycles after the last `o_valid`. `o_issue_cnt`=3.
- `i_mode`=1, push 6 words → `o_cmd` sequence 0, 1, 2, 3, 0, 1. Then set `i_mode`=0 with `i_dest`=2 and push 1 word → `o_cmd`=2; a following `i_mode`=1 word gets `o_cmd`=2 (`rr_ptr` continued from 2).
- `i_issue_en`=0, push until full → `o_ready` goes 0 after 4 accepts and the 5th word is held off. Raise `i_issue_en` → `o_ready` returns to 1 one cycle after the first pop, and all 5 words issue in order.
- Single issue, then `i_issue_en`=0 → `o_en`=1 for exactly NUM_NODE=4 cycles, then 0. `o_busy` falls on the same edge.
- With NUM_NODE=3: push a word with `i_dest`=3 → `o_valid` stays 0, `o_drop_cnt`=1, and the next legal word issues normally.
- Assert `rst` for 1 cycle while the FIFO holds 2 words and `o_en`=1 → next cycle all outputs are zero, `o_ready`=1, both counters are 0, and no further `o_valid` appears.

Source files
------------

// File: rtl/linear_network_dispatcher_if.sv
// Upstream stream + network drive bundle for linear_network_dispatcher.
// master: feeder side (drives i_*), slave: dispatcher side (drives o_*).
interface linear_network_dispatcher_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4
);
    localparam int CMD_W = $clog2(NUM_NODE);

    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic [CMD_W-1:0]      i_dest;
    logic                  o_ready;
    logic                  i_mode;
    logic                  i_issue_en;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data_bus;
    logic [CMD_W-1:0]      o_cmd;
    logic                  o_en;
    logic                  o_busy;
    logic [15:0]           o_issue_cnt;
    logic [15:0]           o_drop_cnt;

    modport master (
        output i_valid, i_data, i_dest, i_mode, i_issue_en,
        input  o_ready, o_valid, o_data_bus, o_cmd, o_en, o_busy,
               o_issue_cnt, o_drop_cnt
    );

    modport slave (
        input  i_valid, i_data, i_dest, i_mode, i_issue_en,
        output o_ready, o_valid, o_data_bus, o_cmd, o_en, o_busy,
               o_issue_cnt, o_drop_cnt
    );
endinterface

// File: rtl/linear_network_dispatcher.sv
// Feeder for the sequential unicast linear network: buffers tagged words in
// a small FIFO, issues one per cycle as valid/data/cmd, and keeps the network
// enable high until the last issued word has reached the final node.
module linear_network_dispatcher #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    linear_network_dispatcher_if.slave bus
);
    localparam int CMD_W = $clog2(NUM_NODE);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = CMD_W + DATA_WIDTH;
    localparam logic [CMD_W-1:0] RR_LAST    = CMD_W'(NUM_NODE - 1);
    localparam logic [CMD_W:0]   DRAIN_LOAD = (CMD_W + 1)'(NUM_NODE - 1);
    localparam logic [CMD_W:0]   NODE_LIM   = (CMD_W + 1)'(NUM_NODE);

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [CMD_W-1:0]      rr_ptr;
    logic [CMD_W:0]        drain_cnt;
    logic                  empty, full, push, pop, legal, issue;
    logic [CMD_W-1:0]      push_dest, head_dest;
    logic [DATA_WIDTH-1:0] head_data;

    // Extra pointer MSB separates full from empty after wrap-around.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign bus.o_ready = ~full;
    assign push      = bus.i_valid && !full;
    assign pop       = bus.i_issue_en && !empty;
    assign push_dest = bus.i_mode ? rr_ptr : bus.i_dest;
    assign {head_dest, head_data} = mem[rd_ptr[AW-1:0]];
    assign issue     = pop && legal;
    assign bus.o_busy = !empty || bus.o_en;

    // Only a non-power-of-2 node count leaves unused codes to reject.
    generate
        if ((1 << CMD_W) == NUM_NODE) begin : g_all_legal
            assign legal = 1'b1;
        end else begin : g_range_chk
            assign legal = ({1'b0, head_dest} < NODE_LIM);
        end
    endgenerate

    // FIFO storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {push_dest, bus.i_data};
    end

    // FIFO pointers and round-robin destination pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && bus.i_mode)
                rr_ptr <= (rr_ptr == RR_LAST) ? '0 : rr_ptr + 1'b1;
        end
    end

    // Registered network drive, drain timer and statistics counters.
    // Illegal destinations are consumed but present an idle (all-zero) cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_valid     <= 1'b0;
            bus.o_data_bus  <= '0;
            bus.o_cmd       <= '0;
            bus.o_en        <= 1'b0;
            bus.o_issue_cnt <= '0;
            bus.o_drop_cnt  <= '0;
            drain_cnt       <= '0;
        end else begin
            bus.o_valid    <= issue;
            bus.o_data_bus <= issue ? head_data : '0;
            bus.o_cmd      <= issue ? head_dest : '0;
            // Enable covers the issue cycle plus NUM_NODE-1 propagation cycles.
            bus.o_en       <= issue || (drain_cnt != '0);
            if (issue)                  drain_cnt <= DRAIN_LOAD;
            else if (drain_cnt != '0)   drain_cnt <= drain_cnt - 1'b1;
            if (issue)                  bus.o_issue_cnt <= bus.o_issue_cnt + 1'b1;
            if (pop && !legal)          bus.o_drop_cnt  <= bus.o_drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_linear_network_dispatcher.sv
// Directed bench for linear_network_dispatcher: a 4-node instance for the main
// flows and a 3-node instance for illegal-destination dropping.
module tb_linear_network_dispatcher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    linear_network_dispatcher_if #(.DATA_WIDTH(32), .NUM_NODE(4)) if4 ();
    linear_network_dispatcher_if #(.DATA_WIDTH(32), .NUM_NODE(3)) if3 ();

    linear_network_dispatcher #(.DATA_WIDTH(32), .NUM_NODE(4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .bus(if4.slave));
    linear_network_dispatcher #(.DATA_WIDTH(32), .NUM_NODE(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst(rst), .bus(if3.slave));

    // Capture of every issued word (observed mid-cycle).
    logic [1:0]  q_cmd [$];
    logic [31:0] q_data[$];
    int          q_cyc [$];
    int          v3_cnt = 0;
    logic [1:0]  last3_cmd;
    logic [31:0] last3_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (if4.o_valid) begin
                q_cmd.push_back(if4.o_cmd);
                q_data.push_back(if4.o_data_bus);
                q_cyc.push_back(cyc);
            end
            if (if3.o_valid) begin
                v3_cnt     = v3_cnt + 1;
                last3_cmd  = if3.o_cmd;
                last3_data = if3.o_data_bus;
            end
        end
    end

    // Present one word and hold it until accepted; returns mid-cycle after the accepting edge.
    task automatic push(input int which, input logic [31:0] d, input logic [1:0] dest, input logic mode);
        int t = 0;
        if (which == 4) begin
            if4.i_valid = 1'b1; if4.i_data = d; if4.i_dest = dest; if4.i_mode = mode;
            while (!if4.o_ready && t < 50) begin @(negedge clk); t++; end
        end else begin
            if3.i_valid = 1'b1; if3.i_data = d; if3.i_dest = dest; if3.i_mode = mode;
            while (!if3.o_ready && t < 50) begin @(negedge clk); t++; end
        end
        @(negedge clk);
        if4.i_valid = 1'b0;
        if3.i_valid = 1'b0;
        tests++;
        if (t >= 50) begin fails++; $display("FAIL push_timeout got waited=%0d exp <50", t); end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((if4.o_busy || if3.o_busy) && t < 100) begin @(negedge clk); t++; end
        tests++;
        if (t >= 100) begin fails++; $display("FAIL idle_timeout got waited=%0d exp <100", t); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({if4.o_valid, if4.o_en, if4.o_cmd, if4.o_data_bus} !== 36'h0) begin
            fails++; $display("FAIL reset_outputs got %h exp 0", {if4.o_valid, if4.o_en, if4.o_cmd, if4.o_data_bus});
        end
        tests++;
        if ({if4.o_ready, if4.o_busy} !== 2'b10) begin
            fails++; $display("FAIL reset_ready_busy got %b exp 10", {if4.o_ready, if4.o_busy});
        end
        tests++;
        if ({if4.o_issue_cnt, if4.o_drop_cnt} !== 32'h0) begin
            fails++; $display("FAIL reset_counters got %h exp 0", {if4.o_issue_cnt, if4.o_drop_cnt});
        end
        tests++;
        if ({if3.o_valid, if3.o_en, if3.o_ready, if3.o_busy} !== 4'b0010) begin
            fails++; $display("FAIL reset_dut3 got %b exp 0010", {if3.o_valid, if3.o_en, if3.o_ready, if3.o_busy});
        end
    endtask

    task automatic test_explicit();
        logic [4:0] en_seq, busy_seq;
        if4.i_issue_en = 1'b1; if4.i_mode = 1'b0;
        if4.i_valid = 1'b1; if4.i_data = 32'hA1; if4.i_dest = 2'd3;
        @(negedge clk);
        tests++;
        if (if4.o_valid !== 1'b0) begin fails++; $display("FAIL explicit_no_bypass got %b exp 0", if4.o_valid); end
        if4.i_data = 32'hB2; if4.i_dest = 2'd0;
        @(negedge clk);
        tests++;
        if ({if4.o_valid, if4.o_cmd, if4.o_data_bus} !== {1'b1, 2'd3, 32'hA1}) begin
            fails++; $display("FAIL explicit_w0 got %h exp %h", {if4.o_valid, if4.o_cmd, if4.o_data_bus}, {1'b1, 2'd3, 32'hA1});
        end
        if4.i_data = 32'hC3; if4.i_dest = 2'd2;
        @(negedge clk);
        tests++;
        if ({if4.o_valid, if4.o_cmd, if4.o_data_bus} !== {1'b1, 2'd0, 32'hB2}) begin
            fails++; $display("FAIL explicit_w1 got %h exp %h", {if4.o_valid, if4.o_cmd, if4.o_data_bus}, {1'b1, 2'd0, 32'hB2});
        end
        if4.i_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({if4.o_valid, if4.o_cmd, if4.o_data_bus, if4.o_en} !== {1'b1, 2'd2, 32'hC3, 1'b1}) begin
            fails++; $display("FAIL explicit_w2 got %h exp %h", {if4.o_valid, if4.o_cmd, if4.o_data_bus, if4.o_en}, {1'b1, 2'd2, 32'hC3, 1'b1});
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            en_seq[k]   = if4.o_en;
            busy_seq[k] = if4.o_busy;
        end
        tests++;
        if (en_seq !== 5'b00111) begin fails++; $display("FAIL explicit_en_tail got %b exp 00111", en_seq); end
        tests++;
        if (busy_seq !== 5'b00111) begin fails++; $display("FAIL explicit_busy_tail got %b exp 00111", busy_seq); end
        tests++;
        if (if4.o_issue_cnt !== 16'd3) begin fails++; $display("FAIL explicit_issue_cnt got %0d exp 3", if4.o_issue_cnt); end
    endtask

    task automatic test_round_robin();
        int base = q_cmd.size();
        logic [1:0]  exp_cmd [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd2};
        logic [31:0] exp_data[8] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h200, 32'h201};
        if4.i_issue_en = 1'b1;
        for (int i = 0; i < 6; i++) push(4, 32'h100 + i, 2'd3, 1'b1);
        push(4, 32'h200, 2'd2, 1'b0);
        push(4, 32'h201, 2'd3, 1'b1);
        wait_idle();
        tests++;
        if (q_cmd.size() - base !== 8) begin
            fails++; $display("FAIL rr_count got %0d exp 8", q_cmd.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if ({q_cmd[base+i], q_data[base+i]} !== {exp_cmd[i], exp_data[i]}) begin
                    fails++; $display("FAIL rr_word%0d got %h exp %h", i, {q_cmd[base+i], q_data[base+i]}, {exp_cmd[i], exp_data[i]});
                end
            end
            tests++;
            if (q_cyc[base+7] - q_cyc[base] !== 7) begin
                fails++; $display("FAIL rr_throughput got span=%0d exp 7", q_cyc[base+7] - q_cyc[base]);
            end
        end
        tests++;
        if (if4.o_issue_cnt !== 16'd11) begin fails++; $display("FAIL rr_issue_cnt got %0d exp 11", if4.o_issue_cnt); end
    endtask

    task automatic test_full();
        int base = q_cmd.size();
        if4.i_issue_en = 1'b0;
        for (int i = 0; i < 4; i++) push(4, 32'h300 + i, 2'(i), 1'b0);
        tests++;
        if ({if4.o_ready, if4.o_busy} !== 2'b01) begin
            fails++; $display("FAIL full_ready got %b exp 01", {if4.o_ready, if4.o_busy});
        end
        if4.i_valid = 1'b1; if4.i_data = 32'h304; if4.i_dest = 2'd0; if4.i_mode = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({if4.o_ready, 32'(q_cmd.size() - base)} !== {1'b0, 32'd0}) begin
            fails++; $display("FAIL full_held_off got ready=%b issued=%0d exp ready=0 issued=0", if4.o_ready, q_cmd.size() - base);
        end
        if4.i_issue_en = 1'b1;
        @(negedge clk);
        tests++;
        if (if4.o_ready !== 1'b1) begin fails++; $display("FAIL full_ready_return got %b exp 1", if4.o_ready); end
        @(negedge clk);
        if4.i_valid = 1'b0;
        wait_idle();
        tests++;
        if (q_cmd.size() - base !== 5) begin
            fails++; $display("FAIL full_count got %0d exp 5", q_cmd.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if ({q_cmd[base+i], q_data[base+i]} !== {2'(i), 32'h300 + 32'(i)}) begin
                    fails++; $display("FAIL full_word%0d got %h exp %h", i, {q_cmd[base+i], q_data[base+i]}, {2'(i), 32'h300 + 32'(i)});
                end
            end
        end
    endtask

    task automatic test_drain();
        logic [5:0] en_seq, busy_seq;
        if4.i_issue_en = 1'b1;
        push(4, 32'h400, 2'd1, 1'b0);
        @(negedge clk);
        tests++;
        if ({if4.o_valid, if4.o_en} !== 2'b11) begin
            fails++; $display("FAIL drain_issue got %b exp 11", {if4.o_valid, if4.o_en});
        end
        if4.i_issue_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            en_seq[k]   = if4.o_en;
            busy_seq[k] = if4.o_busy;
        end
        tests++;
        if (en_seq !== 6'b000111) begin fails++; $display("FAIL drain_en got %b exp 000111", en_seq); end
        tests++;
        if (busy_seq !== 6'b000111) begin fails++; $display("FAIL drain_busy got %b exp 000111", busy_seq); end
    endtask

    task automatic test_illegal();
        int base3 = v3_cnt;
        if3.i_issue_en = 1'b1;
        push(3, 32'h500, 2'd3, 1'b0);
        repeat (3) @(negedge clk);
        tests++;
        if ({32'(v3_cnt - base3), if3.o_drop_cnt, if3.o_en} !== {32'd0, 16'd1, 1'b0}) begin
            fails++; $display("FAIL illegal_drop got valids=%0d drop=%0d en=%b exp 0 1 0", v3_cnt - base3, if3.o_drop_cnt, if3.o_en);
        end
        push(3, 32'h501, 2'd1, 1'b0);
        repeat (3) @(negedge clk);
        tests++;
        if ({32'(v3_cnt - base3), last3_cmd, last3_data, if3.o_issue_cnt, if3.o_drop_cnt} !==
            {32'd1, 2'd1, 32'h501, 16'd1, 16'd1}) begin
            fails++; $display("FAIL illegal_next_legal got n=%0d cmd=%0d data=%h issue=%0d drop=%0d exp 1 1 501 1 1",
                              v3_cnt - base3, last3_cmd, last3_data, if3.o_issue_cnt, if3.o_drop_cnt);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int base;
        if4.i_issue_en = 1'b1;
        push(4, 32'h600, 2'd0, 1'b0);
        push(4, 32'h601, 2'd1, 1'b0);
        if4.i_issue_en = 1'b0;
        push(4, 32'h602, 2'd2, 1'b0);
        tests++;
        if ({if4.o_en, if4.o_ready, if4.o_busy} !== 3'b111) begin
            fails++; $display("FAIL midrst_setup got %b exp 111", {if4.o_en, if4.o_ready, if4.o_busy});
        end
        rst = 1'b1;
        if4.i_issue_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({if4.o_valid, if4.o_en, if4.o_cmd, if4.o_data_bus, if4.o_ready, if4.o_busy} !== {36'h0, 2'b10}) begin
            fails++; $display("FAIL midrst_outputs got %h exp %h",
                              {if4.o_valid, if4.o_en, if4.o_cmd, if4.o_data_bus, if4.o_ready, if4.o_busy}, {36'h0, 2'b10});
        end
        tests++;
        if ({if4.o_issue_cnt, if4.o_drop_cnt} !== 32'h0) begin
            fails++; $display("FAIL midrst_counters got %h exp 0", {if4.o_issue_cnt, if4.o_drop_cnt});
        end
        base = q_cmd.size();
        repeat (10) @(negedge clk);
        tests++;
        if (q_cmd.size() - base !== 0) begin fails++; $display("FAIL midrst_no_issue got %0d exp 0", q_cmd.size() - base); end
    endtask

    initial begin
        if4.i_valid = 1'b0; if4.i_data = '0; if4.i_dest = '0; if4.i_mode = 1'b0; if4.i_issue_en = 1'b0;
        if3.i_valid = 1'b0; if3.i_data = '0; if3.i_dest = '0; if3.i_mode = 1'b0; if3.i_issue_en = 1'b0;
        test_reset();
        test_explicit();
        test_round_robin();
        test_full();
        test_drain();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
